// File: rtl/ro_measure_sequencer_pkg.sv
// Shared encodings for the ring-oscillator measurement sequencer:
// UART command codes, oscillator configuration codes and the FSM states.
package ro_measure_sequencer_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_SINGLE = 2'b01,
    CMD_CONT   = 2'b10,
    CMD_STOP   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    OSC_INV  = 2'b00,
    OSC_NAND = 2'b01,
    OSC_ALT  = 2'b10,
    OSC_RSVD = 2'b11
  } osc_cfg_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_GATE    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_EMIT    = 3'd5
  } state_e;

  // Largest of three cycle counts; sizes the shared duration timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ro_measure_sequencer_if.sv
// Command and result channels between the UART side and the sequencer.
//
// Handshake: cmd_valid is a one-cycle strobe with no back-pressure; cmd and
// cfg_osc are only meaningful while it is high. The result channel is strict
// valid/ready: once res_valid rises, res_valid, res_data and res_osc hold
// steady until a cycle with res_valid && res_ready, which is the transfer.
// res_ready while res_valid is low has no effect.
interface ro_measure_sequencer_if #(
  parameter int ACC_W = 24
);
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic [1:0]       cfg_osc;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_osc;

  // Host side: issues commands, consumes results.
  modport master (
    output cmd_valid, cmd, cfg_osc, res_ready,
    input  res_valid, res_data, res_osc
  );

  // Sequencer side: accepts commands, produces results.
  modport slave (
    input  cmd_valid, cmd, cfg_osc, res_ready,
    output res_valid, res_data, res_osc
  );
endinterface

// File: rtl/ro_measure_sequencer_seq_timer.sv
// Loadable down-counter. Loading N-1 on the transition into a state makes
// done rise in that state's Nth cycle, so one timer serves every duration.
module ro_measure_sequencer_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Sequences one ring-oscillator temperature conversion: settle the selected
// oscillator, run 2^AVG_LOG2 gated count windows, sum the counts and hand
// the sum to the UART serializer. Supports single, continuous and
// oscillator-alternating operation. reset is active low.
module ro_measure_sequencer
  import ro_measure_sequencer_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ACC_W        = 24,
  parameter int AVG_LOG2     = 3,
  parameter int SETTLE_CYC   = 64,
  parameter int GATE_CYC     = 1000,
  parameter int CAPTURE_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ro_measure_sequencer_if.slave   bus,
  input  logic [CNT_W-1:0]        cnt_value,
  output logic                    osc_en_inv,
  output logic                    osc_en_nand,
  output logic                    osc_sel,
  output logic                    cnt_clear,
  output logic                    cnt_en,
  output logic                    busy,
  output state_e                  dbg_state
);

  localparam int NSAMP   = 1 << AVG_LOG2;
  localparam int SW      = AVG_LOG2 + 1;
  localparam int MAX_CYC = max3(SETTLE_CYC, GATE_CYC, CAPTURE_WAIT);
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] GATE_LD    = TW'(GATE_CYC - 1);
  localparam logic [TW-1:0] CAPTURE_LD = TW'(CAPTURE_WAIT - 1);
  localparam logic [SW-1:0] LAST_SMP   = SW'(NSAMP - 1);

  // The sum of NSAMP full-scale counts must fit the accumulator.
  if (ACC_W < CNT_W + AVG_LOG2) begin : g_acc_width_check
    $error("ro_measure_sequencer: ACC_W must be >= CNT_W + AVG_LOG2");
  end

  state_e           state_q,   state_d;
  logic             cont_q,    cont_d;
  osc_cfg_e         mode_q,    mode_d;
  logic             osc_sel_q, osc_sel_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [SW-1:0]    smp_q,     smp_d;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_done;
  logic             is_start;
  logic             is_stop;
  logic             cont_eff;
  logic             running;

  ro_measure_sequencer_seq_timer #(.W(TW)) u_seq_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state, datapath updates and timer loads.
  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    mode_d    = mode_q;
    osc_sel_d = osc_sel_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    cont_eff  = cont_q;
    is_start  = bus.cmd_valid && ((bus.cmd == CMD_SINGLE) || (bus.cmd == CMD_CONT));
    is_stop   = bus.cmd_valid && (bus.cmd == CMD_STOP);

    case (state_q)
      ST_IDLE: begin
        if (is_start) begin
          cont_d    = (bus.cmd == CMD_CONT);
          // The reserved code behaves like the inverter oscillator.
          mode_d    = (bus.cfg_osc == OSC_RSVD) ? OSC_INV : osc_cfg_e'(bus.cfg_osc);
          osc_sel_d = (bus.cfg_osc == OSC_NAND);
          acc_d     = '0;
          smp_d     = '0;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = GATE_LD;
          state_d  = ST_GATE;
        end
      end

      ST_GATE: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CAPTURE_LD;
          state_d  = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          // Counter synchronizer has settled by the last wait cycle.
          acc_d   = acc_q + ACC_W'(cnt_value);
          smp_d   = smp_q + SW'(1);
          state_d = (smp_q == LAST_SMP) ? ST_EMIT : ST_CLEAR;
        end
      end

      ST_EMIT: begin
        // STOP here only cancels the follow-on conversion.
        cont_eff = cont_q && !is_stop;
        cont_d   = cont_eff;
        if (bus.res_ready) begin
          if (cont_eff) begin
            if (mode_q == OSC_ALT) begin
              osc_sel_d = ~osc_sel_q;
            end
            acc_d    = '0;
            smp_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cont_q    <= 1'b0;
      mode_q    <= OSC_INV;
      osc_sel_q <= 1'b0;
      acc_q     <= '0;
      smp_q     <= '0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      mode_q    <= mode_d;
      osc_sel_q <= osc_sel_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
    end
  end

  // Outputs decoded from registered state only; the oscillator is powered
  // from SETTLE through CAPTURE and off while the result waits in EMIT.
  always_comb begin
    running       = (state_q == ST_SETTLE) || (state_q == ST_CLEAR) ||
                    (state_q == ST_GATE)   || (state_q == ST_CAPTURE);
    osc_en_inv    = running && !osc_sel_q;
    osc_en_nand   = running && osc_sel_q;
    osc_sel       = osc_sel_q;
    cnt_clear     = (state_q == ST_CLEAR);
    cnt_en        = (state_q == ST_GATE);
    busy          = (state_q != ST_IDLE);
    bus.res_valid = (state_q == ST_EMIT);
    bus.res_data  = acc_q;
    bus.res_osc   = osc_sel_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Bench for ro_measure_sequencer with short timing parameters. A timeline
// model (phase derived from cycles elapsed since a conversion began) is
// compared with the DUT every cycle; directed scenarios pin hand-computed
// latencies, sums and pulse counts.
module tb_ro_measure_sequencer;
  import ro_measure_sequencer_pkg::*;

  localparam int CNT_W    = 16;
  localparam int ACC_W    = 24;
  localparam int AVG_LOG2 = 2;
  localparam int SETTLE   = 4;
  localparam int GATE     = 10;
  localparam int CAPW     = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int PER      = 1 + GATE + CAPW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] cnt_value = '0;
  logic osc_en_inv, osc_en_nand, osc_sel, cnt_clear, cnt_en, busy;
  state_e dbg_state;

  ro_measure_sequencer_if #(.ACC_W(ACC_W)) bus_if ();

  ro_measure_sequencer #(
    .CNT_W(CNT_W), .ACC_W(ACC_W), .AVG_LOG2(AVG_LOG2),
    .SETTLE_CYC(SETTLE), .GATE_CYC(GATE), .CAPTURE_WAIT(CAPW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .cnt_value   (cnt_value),
    .osc_en_inv  (osc_en_inv),
    .osc_en_nand (osc_en_nand),
    .osc_sel     (osc_sel),
    .cnt_clear   (cnt_clear),
    .cnt_en      (cnt_en),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [ACC_W:0] exp_q[$];   // {res_osc, res_data}
  int results_seen = 0;
  int clr_cnt = 0, en_cnt = 0, inv_cnt = 0, nand_cnt = 0;
  int cmd_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  bit             m_active = 1'b0;
  int             m_k      = 0;
  bit             m_cont   = 1'b0;
  int             m_mode   = 0;
  bit             m_sel    = 1'b0;
  logic [ACC_W-1:0] m_acc  = '0;

  // 0 settle, 1 clear, 2 gate, 3 capture, 4 result waiting
  function automatic int phase_of(input int k);
    int j;
    if (k < SETTLE) return 0;
    j = k - SETTLE;
    if (j / PER >= NS) return 4;
    if (j % PER == 0) return 1;
    if (j % PER <= GATE) return 2;
    return 3;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 0; m_k = 0; m_cont = 0; m_mode = 0; m_sel = 0; m_acc = '0;
    end else if (!m_active) begin
      if (bus_if.cmd_valid && (bus_if.cmd == 2'b01 || bus_if.cmd == 2'b10)) begin
        m_active = 1;
        m_k      = 0;
        m_cont   = (bus_if.cmd == 2'b10);
        m_mode   = (bus_if.cfg_osc == 2'b11) ? 0 : int'(bus_if.cfg_osc);
        m_sel    = (m_mode == 1);
        m_acc    = '0;
      end
    end else begin
      bit stop;
      stop = bus_if.cmd_valid && (bus_if.cmd == 2'b11);
      if (phase_of(m_k) != 4) begin
        if (stop) begin
          m_active = 0;
        end else begin
          if (phase_of(m_k) == 3 && ((m_k - SETTLE) % PER == PER - 1))
            m_acc = m_acc + ACC_W'(cnt_value);
          m_k++;
        end
      end else begin
        if (stop) m_cont = 0;
        if (bus_if.res_ready) begin
          if (m_cont) begin
            if (m_mode == 2) m_sel = !m_sel;
            m_k = 0;
            m_acc = '0;
          end else begin
            m_active = 0;
          end
        end
      end
    end
  end

  // ---------------- compare / scoreboard ----------------
  initial forever begin
    int ph;
    logic [6:0] exp_v, act_v;
    logic [ACC_W:0] e;
    @(negedge clk);
    ph = m_active ? phase_of(m_k) : 5;
    exp_v = {m_active && ph <= 3 && !m_sel, m_active && ph <= 3 && m_sel, m_sel,
             ph == 1, ph == 2, ph == 4, m_active};
    act_v = {osc_en_inv, osc_en_nand, osc_sel, cnt_clear, cnt_en, bus_if.res_valid, busy};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs: got %b want %b (cycle %0d)", act_v, exp_v, cyc);
    end
    if (ph == 4) chk("model_res", {bus_if.res_osc, bus_if.res_data}, {m_sel, m_acc});
    if (cnt_clear)   clr_cnt++;
    if (cnt_en)      en_cnt++;
    if (osc_en_inv)  inv_cnt++;
    if (osc_en_nand) nand_cnt++;
    if (bus_if.res_valid && bus_if.res_ready) begin
      results_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", {bus_if.res_osc, bus_if.res_data}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic [1:0] c, input logic [1:0] o);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd       = c;
    bus_if.cfg_osc   = o;
    cmd_cyc          = cyc;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = 2'b00;
  endtask

  task automatic wait_res(input int budget, output int at);
    bit seen;
    seen = 0;
    at = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus_if.res_valid) begin
        seen = 1;
        at = cyc;
      end
    end
    if (!seen) chk("res_valid_timeout", 0, 1);
  endtask

  function automatic logic [6:0] out_vec();
    return {osc_en_inv, osc_en_nand, osc_sel, cnt_clear, cnt_en, bus_if.res_valid, busy};
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int at, c0, vseen;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = 2'b00;
    bus_if.cfg_osc   = 2'b00;
    bus_if.res_ready = 1'b1;

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", out_vec(), 7'd0);
    chk("reset_res_data", bus_if.res_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single conversion, inverter oscillator
    cnt_value = 16'd100;
    exp_q.push_back({1'b0, 24'd400});
    clr_cnt = 0; en_cnt = 0;
    issue_cmd(2'b01, 2'b00);
    wait_res(200, at);
    chk("single_latency", at - cmd_cyc, 57);
    chk("single_data", bus_if.res_data, 400);
    chk("single_osc", bus_if.res_osc, 0);
    repeat (3) @(posedge clk); #1;
    chk("single_clear_pulses", clr_cnt, 4);
    chk("single_gate_cycles", en_cnt, 40);
    chk("single_idle_after", busy, 0);

    // Continuous alternate, full-scale counts
    cnt_value = 16'hFFFF;
    exp_q.push_back({1'b0, 24'h3FFFC});
    exp_q.push_back({1'b1, 24'h3FFFC});
    inv_cnt = 0; nand_cnt = 0;
    issue_cmd(2'b10, 2'b10);
    wait_res(200, at);
    chk("alt1_data", bus_if.res_data, 24'h3FFFC);
    chk("alt1_osc", bus_if.res_osc, 0);
    chk("alt1_nand_cycles", nand_cnt, 0);
    chk("alt1_inv_cycles", inv_cnt, 56);
    wait_res(200, at);
    chk("alt2_data", bus_if.res_data, 24'h3FFFC);
    chk("alt2_osc", bus_if.res_osc, 1);
    chk("alt2_nand_cycles", nand_cnt, 56);
    chk("alt2_inv_cycles", inv_cnt, 56);
    issue_cmd(2'b11, 2'b00);
    chk("alt_stop_idle", out_vec() & 7'b1101111, 7'd0);

    // Continuous NAND with a stalled consumer, then STOP while the result waits
    bus_if.res_ready = 1'b0;
    cnt_value = 16'd7;
    exp_q.push_back({1'b1, 24'd28});
    exp_q.push_back({1'b1, 24'd28});
    issue_cmd(2'b10, 2'b01);
    wait_res(200, at);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_vec(), bus_if.res_osc, bus_if.res_data},
          {7'b0010011, 1'b1, 24'd28});
    end
    @(posedge clk); #1; bus_if.res_ready = 1'b1;
    @(posedge clk); #1; bus_if.res_ready = 1'b0;
    @(negedge clk);
    chk("stall_next_starts", {osc_en_nand, bus_if.res_valid}, 2'b10);
    wait_res(200, at);
    issue_cmd(2'b11, 2'b00);
    chk("emit_stop_holds", {bus_if.res_valid, busy}, 2'b11);
    bus_if.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("emit_stop_idle", busy, 0);

    // STOP during the second gate window
    cnt_value = 16'd50;
    clr_cnt = 0;
    issue_cmd(2'b01, 2'b00);
    for (int n = 0; n < 200 && clr_cnt < 2; n++) @(negedge clk);
    repeat (3) @(posedge clk); #1;
    chk("second_gate_open", cnt_en, 1);
    issue_cmd(2'b11, 2'b00);
    chk("abort_idle", out_vec() & 7'b1101111, 7'd0);
    vseen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus_if.res_valid) vseen++;
    end
    chk("abort_no_result", vseen, 0);

    // Fresh SINGLE after abort; start commands mid-conversion are ignored
    cnt_value = 16'd9;
    exp_q.push_back({1'b0, 24'd36});
    issue_cmd(2'b01, 2'b00);
    c0 = cmd_cyc;
    repeat (20) @(posedge clk);
    issue_cmd(2'b01, 2'b01);
    issue_cmd(2'b10, 2'b10);
    wait_res(200, at);
    chk("busy_cmd_latency", at - c0, 57);
    chk("clean_sum", {bus_if.res_osc, bus_if.res_data}, {1'b0, 24'd36});
    repeat (3) @(posedge clk); #1;
    chk("still_single", busy, 0);

    // Asynchronous reset in the middle of a gate window
    cnt_value = 16'd100;
    issue_cmd(2'b01, 2'b00);
    repeat (12) @(posedge clk); #1;
    chk("pre_reset_gate", cnt_en, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 7'd0);
    chk("async_reset_data", bus_if.res_data, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", busy, 0);

    repeat (3) @(posedge clk); #1;
    chk("results_delivered", results_seen, 6);
    chk("expected_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
